// File: rtl/xmul_seq_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : xmul_seq_driver_if
// Description : Operand stream, multiplier bus and result stream of the
//               multiplier sequencer, bundled with sequencer/environment views.
// Revision    : 1.0 - initial release
// ============================================================================
interface xmul_seq_driver_if #(
    parameter int WIDTH = 8
);
    logic                 op_valid;
    logic                 op_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [WIDTH-1:0]     mul_in;
    logic                 mul_a_apply;
    logic                 mul_b_apply;
    logic [2*WIDTH-1:0]   mul_out;
    logic                 res_valid;
    logic                 res_ready;
    logic [2*WIDTH-1:0]   res_data;

    // Sequencer side: it masters the multiplier bus and both stream outputs.
    modport master (
        input  op_valid, op_a, op_b, mul_out, res_ready,
        output op_ready, mul_in, mul_a_apply, mul_b_apply, res_valid, res_data
    );

    modport slave (
        output op_valid, op_a, op_b, mul_out, res_ready,
        input  op_ready, mul_in, mul_a_apply, mul_b_apply, res_valid, res_data
    );
endinterface
`default_nettype wire

// File: rtl/xmul_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : xmul_seq_driver
// Description : Replays operand pairs onto a pulse-latched multiplier bus as
//               registered strobes, waits SETTLE_CYCLES (1..15), returns product.
// Revision    : 1.0 - initial release
// ============================================================================
module xmul_seq_driver #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    xmul_seq_driver_if.master    bus,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_A   = 3'd1,
        S_STROBE_A = 3'd2,
        S_LOAD_B   = 3'd3,
        S_STROBE_B = 3'd4,
        S_SETTLE   = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);

    state_t                r_state;
    logic [WIDTH-1:0]      r_op_b;
    logic [WIDTH-1:0]      r_mul_in;
    logic                  r_a_apply;
    logic                  r_b_apply;
    logic                  r_res_valid;
    logic [2*WIDTH-1:0]    r_res_data;
    logic [3:0]            r_settle_cnt;

    // Each output register is loaded on the edge entering the state in which
    // it must be valid, so strobes come straight from flops and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op_b       <= '0;
            r_mul_in     <= '0;
            r_a_apply    <= 1'b0;
            r_b_apply    <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_settle_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        r_mul_in <= bus.op_a;
                        r_op_b   <= bus.op_b;
                        r_state  <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    r_a_apply <= 1'b1;
                    r_state   <= S_STROBE_A;
                end
                S_STROBE_A: begin
                    r_a_apply <= 1'b0;
                    r_mul_in  <= r_op_b;
                    r_state   <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    r_b_apply <= 1'b1;
                    r_state   <= S_STROBE_B;
                end
                S_STROBE_B: begin
                    r_b_apply    <= 1'b0;
                    r_settle_cnt <= '0;
                    r_state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + 4'd1;
                    if (r_settle_cnt == c_settle_last) begin
                        r_res_data  <= bus.mul_out;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_a_apply   <= 1'b0;
                    r_b_apply   <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready    = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);
    assign bus.mul_in      = r_mul_in;
    assign bus.mul_a_apply = r_a_apply;
    assign bus.mul_b_apply = r_b_apply;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;

endmodule
`default_nettype wire
